// File: rtl/demux1to32_seq.sv
// Sequential 1-to-WIDTH bit demultiplexer: assembles a word from serial bits written either
// at an addressed index or at an auto-incrementing pointer, pulsing word_valid on completion.
module demux1to32_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             D,
  input  logic [SEL_W-1:0] S,
  input  logic             we,
  input  logic             auto_inc,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] filled,
  output logic [SEL_W-1:0] ptr,
  output logic             busy,
  output logic             word_valid
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   idx;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    idx     = auto_inc ? ptr_q : S;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StFill;
          word_d  = '0;
          mask_d  = '0;
          ptr_d   = '0;
        end
      end
      StFill: begin
        // start overrides a coincident write and aborts the word in progress
        if (start) begin
          word_d = '0;
          mask_d = '0;
          ptr_d  = '0;
        end else if (we) begin
          word_d[idx] = D;
          mask_d[idx] = 1'b1;
          if (auto_inc) ptr_d = ptr_q + 1'b1;
          if (&mask_d) begin
            state_d = StDone;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign O          = word_q;
  assign filled     = mask_q;
  assign ptr        = ptr_q;
  assign busy       = (state_q == StFill);
  assign word_valid = valid_q;

endmodule

// File: tb/tb_demux1to32_seq.sv
// Self-checking bench for demux1to32_seq: a reference model pushes expected outputs into a
// scoreboard queue as stimulus is driven; entries are popped and compared after each edge.
module tb_demux1to32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        D;
  logic [4:0]  S;
  logic        we;
  logic        auto_inc;
  logic [31:0] O;
  logic [31:0] filled;
  logic [4:0]  ptr;
  logic        busy;
  logic        word_valid;

  demux1to32_seq #(
    .WIDTH(32),
    .SEL_W(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .D          (D),
    .S          (S),
    .we         (we),
    .auto_inc   (auto_inc),
    .O          (O),
    .filled     (filled),
    .ptr        (ptr),
    .busy       (busy),
    .word_valid (word_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o;
    logic [31:0] filled;
    logic [4:0]  ptr;
    logic        busy;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  // Reference model state: 0 idle, 1 fill, 2 done
  int          m_state;
  logic [31:0] m_o;
  logic [31:0] m_filled;
  logic [4:0]  m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_o      = '0;
    m_filled = '0;
    m_ptr    = '0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare after the edge.
  task automatic step(input logic st, input logic w, input logic d, input logic [4:0] s,
                      input logic ai, input string tag);
    exp_t e;
    logic nv;
    logic [4:0] ix;
    start = st; we = w; D = d; S = s; auto_inc = ai;
    nv = 1'b0;
    if (st) begin
      m_state = 1; m_o = '0; m_filled = '0; m_ptr = '0;
    end else if (m_state == 1 && w) begin
      ix = ai ? m_ptr : s;
      m_o[ix] = d;
      m_filled[ix] = 1'b1;
      if (ai) m_ptr = m_ptr + 5'd1;
      if (m_filled == 32'hFFFF_FFFF) begin
        m_state = 2;
        nv = 1'b1;
      end
    end
    e.o = m_o; e.filled = m_filled; e.ptr = m_ptr; e.busy = (m_state == 1); e.valid = nv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (word_valid) n_pulses++;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, " O"}, O, e.o);
      check({tag, " filled"}, filled, e.filled);
      check({tag, " ptr"}, {27'd0, ptr}, {27'd0, e.ptr});
      check({tag, " busy"}, {31'd0, busy}, {31'd0, e.busy});
      check({tag, " word_valid"}, {31'd0, word_valid}, {31'd0, e.valid});
    end
  endtask

  logic [31:0] pat;

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; D = 1'b0; S = '0; auto_inc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset O", O, 32'd0);
    check("reset filled", filled, 32'd0);
    check("reset ptr", {27'd0, ptr}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset word_valid", {31'd0, word_valid}, 32'd0);
    rst = 1'b0;

    // Auto fill
    pat = 32'hA5A5_3C3C;
    step(1, 0, 0, 0, 1, "auto start");
    n_pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step(0, 1, pat[i], 5'(31 - i), 1, "auto wr");
      if (i < 31) check("auto early valid", {31'd0, word_valid}, 32'd0);
    end
    check("auto valid", {31'd0, word_valid}, 32'd1);
    check("auto busy drop", {31'd0, busy}, 32'd0);
    check("auto O", O, 32'hA5A5_3C3C);
    check("auto filled", filled, 32'hFFFF_FFFF);
    check("auto ptr", {27'd0, ptr}, 32'd0);
    step(0, 0, 0, 0, 1, "auto idle");
    check("auto pulses", n_pulses, 32'd1);

    // Addressed fill, S from 31 down to 0
    step(1, 0, 0, 0, 0, "addr start");
    n_pulses = 0;
    for (int s = 31; s >= 0; s--) begin
      step(0, 1, (s % 2) == 0, 5'(s), 0, "addr wr");
      check("addr ptr", {27'd0, ptr}, 32'd0);
    end
    check("addr O", O, 32'h5555_5555);
    step(0, 0, 0, 0, 0, "addr idle");
    check("addr pulses", n_pulses, 32'd1);

    // Rewrite: index 3 twice, then the rest
    step(1, 0, 0, 0, 0, "rw start");
    n_pulses = 0;
    step(0, 1, 1, 5'd3, 0, "rw first");
    step(0, 1, 0, 5'd3, 0, "rw second");
    for (int s = 0; s < 32; s++) begin
      if (s != 3) begin
        if (n_pulses != 0) check("rw premature valid", n_pulses, 32'd0);
        step(0, 1, 1, 5'(s), 0, "rw wr");
      end
    end
    check("rw O", O, 32'hFFFF_FFF7);
    check("rw pulses", n_pulses, 32'd1);

    // Abort mid-word with start and we together
    step(1, 0, 0, 0, 1, "abort start");
    n_pulses = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 1, "abort wr");
    step(1, 1, 1, 0, 1, "abort clear");
    check("abort O", O, 32'd0);
    check("abort filled", filled, 32'd0);
    check("abort ptr", {27'd0, ptr}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd1);
    check("abort pulses", n_pulses, 32'd0);
    for (int i = 0; i < 32; i++) step(0, 1, 1, 0, 1, "abort refill");
    check("abort refill O", O, 32'hFFFF_FFFF);
    check("abort refill pulses", n_pulses, 32'd1);

    // Writes in DONE are ignored
    for (int i = 0; i < 3; i++) step(0, 1, 0, 5'(i), i[0], "done wr");
    check("done O held", O, 32'hFFFF_FFFF);
    check("done pulses", n_pulses, 32'd1);

    // Reset mid-word, asserted between edges
    step(1, 0, 0, 0, 1, "rst start");
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 1, "rst wr");
    #2 rst = 1'b1;
    #1;
    check("async O", O, 32'd0);
    check("async filled", filled, 32'd0);
    check("async ptr", {27'd0, ptr}, 32'd0);
    check("async busy", {31'd0, busy}, 32'd0);
    model_reset();
    #1 rst = 1'b0;

    // Writes in IDLE are ignored
    n_pulses = 0;
    for (int i = 0; i < 3; i++) step(0, 1, 1, 5'(i), i[0], "idle wr");
    check("idle O", O, 32'd0);
    check("idle filled", filled, 32'd0);
    check("idle pulses", n_pulses, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/demux1to32_seq.md
Name: demux1to32_seq

Overview:
- Sequential 1-to-WIDTH bit demultiplexer/assembler; the inverse of the 32-to-1 bit selector.
- Takes one serial bit per write and routes it into bit position S of an internal WIDTH-bit word register. S comes from the input port (addressed mode) or from an internal pointer (auto mode).
- Tracks which positions have been written. Signals once, with a one-cycle pulse, when every position of the word has been written.
- Sits at the receive side of a bit-serial path that is produced by the selector.

Parameters:
- WIDTH, 32, output word width; power of two, 2..32.
- SEL_W, 5, select/pointer width; must equal log2(WIDTH).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new word: clear word, mask and pointer, enter FILL.
- D  input  1  serial data bit to be demultiplexed.
- S  input  SEL_W  destination bit index (addressed mode only).
- we  input  1  write strobe for D.
- auto_inc  input  1  1 = use internal pointer as index; 0 = use S.
- O  output  WIDTH  assembled word.
- filled  output  WIDTH  per-bit written mask.
- ptr  output  SEL_W  internal auto-mode pointer.
- busy  output  1  high while in FILL.
- word_valid  output  1  one-cycle pulse when the word completes.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered. On reset: O=0, filled=0, ptr=0, busy=0, word_valid=0, state=IDLE.
- States:
  - IDLE: we is ignored. start -> FILL; O, filled and ptr are cleared in that same edge.
  - FILL: busy=1. A write is performed on each edge with we=1 and start=0. Index is ptr if auto_inc=1, else S.
    - A write sets O[idx]<=D and filled[idx]<=1.
    - In auto mode, ptr<=ptr+1 on each write, wrapping modulo WIDTH. In addressed mode ptr holds.
    - If the post-write mask is all ones: next state DONE, word_valid<=1 for exactly one cycle.
  - DONE: busy=0. O and filled are held; we is ignored. start -> FILL with the full clear.
- Latency:
  - O, filled and ptr reflect a write one cycle after the write edge.
  - word_valid rises in the same cycle as the final write's update, i.e. one clock after the completing edge.
- Boundary conditions:
  - Rewriting an already-filled position in FILL overwrites O[idx]. The mask is unchanged and completion is not triggered early.
  - auto_inc may change between writes. Completion depends only on the mask, never on the pointer value.
  - ptr wraps from WIDTH-1 to 0. A wrap alone does not signal completion.
  - start and we in the same cycle, in any state: start wins, the write is dropped, and the clear is applied.
  - start asserted in FILL aborts the current word (clear, stay in FILL). No word_valid is produced for the aborted word.
  - rst at any time, including mid-word or coincident with word_valid: immediate return to reset values. No pulse survives.
  - S is ignored when auto_inc=1. D and S are don't-care when we=0.

Test Plan:
- Auto fill:
  - Stimulus: reset, start, then 32 consecutive writes with auto_inc=1, D = bits of 0xA5A53C3C LSB-first.
  - Response: O=0xA5A53C3C, filled=0xFFFFFFFF, ptr=0. word_valid is high for exactly one cycle, the cycle after the 32nd write edge. busy drops in that same cycle.
- Addressed fill:
  - Stimulus: start, then writes with auto_inc=0, S=31 down to 0, D=1 only where S is even.
  - Response: O=0x55555555, single word_valid pulse, ptr=0 throughout.
- Rewrite:
  - Stimulus: addressed mode. Write S=3 with D=1, then S=3 with D=0, then the remaining 31 positions with D=1.
  - Response: no word_valid before the 32nd distinct index. Final O=0xFFFFFFF7.
- Abort:
  - Stimulus: start, 10 auto writes of D=1, then start together with we=1.
  - Response: O=0, filled=0, ptr=0, busy=1, no word_valid. The next 32 writes complete normally.
- Ignored writes:
  - Stimulus: we=1 with D=1 in IDLE, and we=1 with D=0 after DONE.
  - Response: O, filled and ptr unchanged. No further word_valid pulse.
- Reset mid-word:
  - Stimulus: assert rst asynchronously (between clock edges) after 20 auto writes.
  - Response: all outputs 0 immediately, state IDLE. Subsequent we is ignored until start.
